// File: rtl/cpu_mem_pkg.sv
// Shared encodings for the data-memory AXI-Lite master: access sizes, AXI response codes,
// FSM states and the store-lane helpers.
package cpu_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StWrReq,
    StWrResp,
    StRdAddr,
    StRdData,
    StDone
  } dmem_state_e;

  // Size 2'b11 falls into the word branch everywhere.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      default: return addr_lo != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] wstrb_of(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 4'b0001 << addr_lo;
      SZ_HALF: return addr_lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wdata_of(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SZ_BYTE: return {4{wdata[7:0]}};
      SZ_HALF: return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/dmem_axi_master_if.sv
// AXI4-Lite master bus bundle between the data-memory master and its slave.
interface dmem_axi_master_if;
  logic [31:0] M_AXI_AWADDR;
  logic [2:0]  M_AXI_AWPROT;
  logic        M_AXI_AWVALID;
  logic        M_AXI_AWREADY;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_WVALID;
  logic        M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP;
  logic        M_AXI_BVALID;
  logic        M_AXI_BREADY;
  logic [31:0] M_AXI_ARADDR;
  logic [2:0]  M_AXI_ARPROT;
  logic        M_AXI_ARVALID;
  logic        M_AXI_ARREADY;
  logic [31:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RVALID;
  logic        M_AXI_RREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    input  M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
    input  M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    output M_AXI_RREADY
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY,
    input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
    output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    input  M_AXI_RREADY
  );
endinterface

// File: rtl/dmem_load_align.sv
// Picks the addressed byte/halfword out of a read word and sign- or zero-extends it.
module dmem_load_align
  import cpu_mem_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_size,
  input  logic        i_sign_ext,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_data = i_rdata;
    case (i_size)
      SZ_BYTE: o_data = {{24{i_sign_ext & w_byte[7]}}, w_byte};
      SZ_HALF: o_data = {{16{i_sign_ext & w_half[15]}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/dmem_axi_master.sv
// MEM-stage load/store unit: turns one CPU access at a time into an AXI4-Lite transaction
// with registered bus outputs and a one-cycle completion pulse.
module dmem_axi_master
  import cpu_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [31:0]       i_cpu_addr,
  input  logic [31:0]       i_cpu_wdata,
  input  logic [1:0]        i_cpu_size,
  input  logic              i_cpu_sign_ext,
  output logic              o_cpu_stall,
  output logic [31:0]       o_cpu_rdata,
  output logic              o_cpu_done,
  output logic              o_cpu_err,
  dmem_axi_master_if.master m_axi
);

  dmem_state_e r_state, w_state_nxt;
  logic [1:0]  r_addr_lo, w_addr_lo_nxt;
  logic [1:0]  r_size, w_size_nxt;
  logic        r_sext, w_sext_nxt;
  logic [31:0] r_awaddr, w_awaddr_nxt;
  logic        r_awvalid, w_awvalid_nxt;
  logic [31:0] r_wdata, w_wdata_nxt;
  logic [3:0]  r_wstrb, w_wstrb_nxt;
  logic        r_wvalid, w_wvalid_nxt;
  logic        r_bready, w_bready_nxt;
  logic [31:0] r_araddr, w_araddr_nxt;
  logic        r_arvalid, w_arvalid_nxt;
  logic        r_rready, w_rready_nxt;
  logic [31:0] r_rdata, w_rdata_nxt;
  logic        r_done, w_done_nxt;
  logic        r_err, w_err_nxt;
  logic [31:0] w_load_data;

  dmem_load_align u_load_align (
    .i_rdata    (m_axi.M_AXI_RDATA),
    .i_addr_lo  (r_addr_lo),
    .i_size     (r_size),
    .i_sign_ext (r_sext),
    .o_data     (w_load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_addr_lo <= 2'b00;
      r_size    <= SZ_BYTE;
      r_sext    <= 1'b0;
      r_awaddr  <= '0;
      r_awvalid <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_araddr  <= '0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_rdata   <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_addr_lo <= w_addr_lo_nxt;
      r_size    <= w_size_nxt;
      r_sext    <= w_sext_nxt;
      r_awaddr  <= w_awaddr_nxt;
      r_awvalid <= w_awvalid_nxt;
      r_wdata   <= w_wdata_nxt;
      r_wstrb   <= w_wstrb_nxt;
      r_wvalid  <= w_wvalid_nxt;
      r_bready  <= w_bready_nxt;
      r_araddr  <= w_araddr_nxt;
      r_arvalid <= w_arvalid_nxt;
      r_rready  <= w_rready_nxt;
      r_rdata   <= w_rdata_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_addr_lo_nxt = r_addr_lo;
    w_size_nxt    = r_size;
    w_sext_nxt    = r_sext;
    w_awaddr_nxt  = r_awaddr;
    w_awvalid_nxt = r_awvalid;
    w_wdata_nxt   = r_wdata;
    w_wstrb_nxt   = r_wstrb;
    w_wvalid_nxt  = r_wvalid;
    w_bready_nxt  = r_bready;
    w_araddr_nxt  = r_araddr;
    w_arvalid_nxt = r_arvalid;
    w_rready_nxt  = r_rready;
    w_rdata_nxt   = r_rdata;
    w_done_nxt    = 1'b0;
    w_err_nxt     = r_err;
    unique case (r_state)
      StIdle: begin
        if (i_cpu_req) begin
          w_addr_lo_nxt = i_cpu_addr[1:0];
          w_size_nxt    = i_cpu_size;
          w_sext_nxt    = i_cpu_sign_ext;
          if (is_misaligned(i_cpu_size, i_cpu_addr[1:0])) begin
            w_state_nxt = StDone;
            w_done_nxt  = 1'b1;
            w_err_nxt   = 1'b1;
          end else if (i_cpu_we) begin
            w_state_nxt   = StWrReq;
            w_awaddr_nxt  = i_cpu_addr;
            w_awvalid_nxt = 1'b1;
            w_wdata_nxt   = wdata_of(i_cpu_size, i_cpu_wdata);
            w_wstrb_nxt   = wstrb_of(i_cpu_size, i_cpu_addr[1:0]);
            w_wvalid_nxt  = 1'b1;
          end else begin
            w_state_nxt   = StRdAddr;
            w_araddr_nxt  = {i_cpu_addr[31:2], 2'b00};
            w_arvalid_nxt = 1'b1;
          end
        end
      end
      StWrReq: begin
        if (m_axi.M_AXI_AWREADY) w_awvalid_nxt = 1'b0;
        if (m_axi.M_AXI_WREADY)  w_wvalid_nxt  = 1'b0;
        // A channel whose valid already dropped has completed its handshake.
        if ((!r_awvalid || m_axi.M_AXI_AWREADY) && (!r_wvalid || m_axi.M_AXI_WREADY)) begin
          w_state_nxt  = StWrResp;
          w_bready_nxt = 1'b1;
        end
      end
      StWrResp: begin
        if (m_axi.M_AXI_BVALID) begin
          w_state_nxt  = StDone;
          w_bready_nxt = 1'b0;
          w_done_nxt   = 1'b1;
          w_err_nxt    = m_axi.M_AXI_BRESP != RESP_OKAY;
        end
      end
      StRdAddr: begin
        if (m_axi.M_AXI_ARREADY) begin
          w_state_nxt   = StRdData;
          w_arvalid_nxt = 1'b0;
          w_rready_nxt  = 1'b1;
        end
      end
      StRdData: begin
        if (m_axi.M_AXI_RVALID) begin
          w_state_nxt  = StDone;
          w_rready_nxt = 1'b0;
          w_rdata_nxt  = w_load_data;
          w_done_nxt   = 1'b1;
          w_err_nxt    = m_axi.M_AXI_RRESP != RESP_OKAY;
        end
      end
      StDone: begin
        w_state_nxt = StIdle;
        w_err_nxt   = 1'b0;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  assign o_cpu_stall = (r_state != StIdle && r_state != StDone) || (r_state == StIdle && i_cpu_req);
  assign o_cpu_rdata = r_rdata;
  assign o_cpu_done  = r_done;
  assign o_cpu_err   = r_err;

  assign m_axi.M_AXI_AWADDR  = r_awaddr;
  assign m_axi.M_AXI_AWPROT  = 3'b000;
  assign m_axi.M_AXI_AWVALID = r_awvalid;
  assign m_axi.M_AXI_WDATA   = r_wdata;
  assign m_axi.M_AXI_WSTRB   = r_wstrb;
  assign m_axi.M_AXI_WVALID  = r_wvalid;
  assign m_axi.M_AXI_BREADY  = r_bready;
  assign m_axi.M_AXI_ARADDR  = r_araddr;
  assign m_axi.M_AXI_ARPROT  = 3'b000;
  assign m_axi.M_AXI_ARVALID = r_arvalid;
  assign m_axi.M_AXI_RREADY  = r_rready;

endmodule

// File: tb/tb_dmem_axi_master.sv
// Bench for dmem_axi_master: delay-programmable AXI-Lite slave, byte-level memory model and a
// scoreboard that checks every completion pulse against the model's expectation.
module tb_dmem_axi_master;
  import cpu_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, cpu_sign_ext = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [1:0]  cpu_size = 2'b00;
  logic        cpu_stall, cpu_done, cpu_err;
  logic [31:0] cpu_rdata;

  dmem_axi_master_if axi ();

  dmem_axi_master dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_cpu_req      (cpu_req),
    .i_cpu_we       (cpu_we),
    .i_cpu_addr     (cpu_addr),
    .i_cpu_wdata    (cpu_wdata),
    .i_cpu_size     (cpu_size),
    .i_cpu_sign_ext (cpu_sign_ext),
    .o_cpu_stall    (cpu_stall),
    .o_cpu_rdata    (cpu_rdata),
    .o_cpu_done     (cpu_done),
    .o_cpu_err      (cpu_err),
    .m_axi          (axi.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          n_aw;
    int          n_w;
    int          n_ar;
    int          n_act;  // -1: bus activity not checked
  } exp_t;

  exp_t        sb[$];
  int          checks = 0, errors = 0;
  logic [7:0]  mb[256];         // reference memory, byte granular
  logic [31:0] smem[64];        // slave storage
  logic [31:0] model_rdata = '0;

  // Slave programming and observations
  int          aw_wait, w_wait, b_dly, ar_wait, r_dly;
  logic        inj_err = 1'b0;
  logic [31:0] exp_awaddr, exp_wdata, exp_araddr;
  logic [3:0]  exp_wstrb;
  int          aw_hs = 0, w_hs = 0, ar_hs = 0, bus_act = 0;
  logic        got_aw = 1'b0, got_w = 1'b0, b_pend = 1'b0, r_pend = 1'b0;
  int          b_wait = 0, r_wait = 0;
  logic [31:0] lat_awaddr, lat_wdata, lat_araddr;
  logic [3:0]  lat_wstrb;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic summary();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  // AXI-Lite slave: handshakes observed on the rising edge, responses driven on the falling edge.
  initial begin
    axi.M_AXI_AWREADY = 1'b0;
    axi.M_AXI_WREADY  = 1'b0;
    axi.M_AXI_BVALID  = 1'b0;
    axi.M_AXI_BRESP   = RESP_OKAY;
    axi.M_AXI_ARREADY = 1'b0;
    axi.M_AXI_RVALID  = 1'b0;
    axi.M_AXI_RRESP   = RESP_OKAY;
    axi.M_AXI_RDATA   = '0;
    forever begin
      @(posedge clk);
      if (axi.M_AXI_AWVALID || axi.M_AXI_WVALID || axi.M_AXI_ARVALID) bus_act++;
      if (axi.M_AXI_AWVALID && axi.M_AXI_AWREADY) begin
        aw_hs++;
        got_aw = 1'b1;
        lat_awaddr = axi.M_AXI_AWADDR;
        check32("awaddr", axi.M_AXI_AWADDR, exp_awaddr);
      end
      if (axi.M_AXI_WVALID && axi.M_AXI_WREADY) begin
        w_hs++;
        got_w = 1'b1;
        lat_wdata = axi.M_AXI_WDATA;
        lat_wstrb = axi.M_AXI_WSTRB;
        check32("wstrb", {28'd0, axi.M_AXI_WSTRB}, {28'd0, exp_wstrb});
        check32("wdata", axi.M_AXI_WDATA, exp_wdata);
      end
      if (got_aw && got_w) begin
        got_aw = 1'b0;
        got_w  = 1'b0;
        for (int k = 0; k < 4; k++)
          if (lat_wstrb[k]) smem[lat_awaddr[7:2]][8*k +: 8] = lat_wdata[8*k +: 8];
        b_pend = 1'b1;
        b_wait = b_dly;
      end
      if (axi.M_AXI_BVALID && axi.M_AXI_BREADY) b_pend = 1'b0;
      if (axi.M_AXI_ARVALID && axi.M_AXI_ARREADY) begin
        ar_hs++;
        lat_araddr = axi.M_AXI_ARADDR;
        check32("araddr", axi.M_AXI_ARADDR, exp_araddr);
        r_pend = 1'b1;
        r_wait = r_dly;
      end
      if (axi.M_AXI_RVALID && axi.M_AXI_RREADY) r_pend = 1'b0;
      @(negedge clk);
      if (axi.M_AXI_AWVALID) begin
        if (aw_wait == 0) axi.M_AXI_AWREADY = 1'b1;
        else aw_wait--;
      end else axi.M_AXI_AWREADY = 1'b0;
      if (axi.M_AXI_WVALID) begin
        if (w_wait == 0) axi.M_AXI_WREADY = 1'b1;
        else w_wait--;
      end else axi.M_AXI_WREADY = 1'b0;
      if (axi.M_AXI_ARVALID) begin
        if (ar_wait == 0) axi.M_AXI_ARREADY = 1'b1;
        else ar_wait--;
      end else axi.M_AXI_ARREADY = 1'b0;
      axi.M_AXI_BRESP = inj_err ? RESP_SLVERR : RESP_OKAY;
      axi.M_AXI_RRESP = inj_err ? RESP_SLVERR : RESP_OKAY;
      if (b_pend) begin
        if (b_wait == 0) axi.M_AXI_BVALID = 1'b1;
        else b_wait--;
      end else axi.M_AXI_BVALID = 1'b0;
      if (r_pend) begin
        axi.M_AXI_RDATA = smem[lat_araddr[7:2]];
        if (r_wait == 0) axi.M_AXI_RVALID = 1'b1;
        else r_wait--;
      end else axi.M_AXI_RVALID = 1'b0;
    end
  end

  // Scoreboard monitor: every completion pulse consumes one expectation.
  initial begin
    exp_t e;
    logic prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (cpu_done) begin
        check1("done_single_cycle", prev_done, 1'b0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          e = sb.pop_front();
          check1("cpu_err", cpu_err, e.err);
          check32("cpu_rdata", cpu_rdata, e.rdata);
          check32("aw_handshakes", aw_hs, e.n_aw);
          check32("w_handshakes", w_hs, e.n_w);
          check32("ar_handshakes", ar_hs, e.n_ar);
          if (e.n_act >= 0) check32("bus_activity", bus_act, e.n_act);
        end
      end
      prev_done = cpu_done;
    end
  end

  // Builds the expectation from access rules, then drives one request and waits for it.
  task automatic run_txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [1:0] sz, input logic sx, input logic ie,
                         input int daw, input int dw, input int db, input int dar, input int dr,
                         input int exp_lat);
    exp_t        e;
    int          n, a8, cyc;
    logic        done_seen;
    logic [31:0] v;
    n  = (sz == SZ_BYTE) ? 1 : (sz == SZ_HALF) ? 2 : 4;
    a8 = int'(a[7:0]);
    e.n_aw = 0; e.n_w = 0; e.n_ar = 0; e.n_act = -1;
    if ((a % n) != 0) begin
      e.err = 1'b1;
      e.rdata = model_rdata;
      e.n_act = 0;
    end else if (we) begin
      exp_awaddr = a;
      exp_wstrb  = '0;
      for (int i = 0; i < n; i++) begin
        mb[(a8 + i) % 256] = wd[8*i +: 8];
        exp_wstrb[int'(a[1:0]) + i] = 1'b1;
      end
      for (int k = 0; k < 4; k++) exp_wdata[8*k +: 8] = wd[8*(k % n) +: 8];
      e.err = ie; e.rdata = model_rdata; e.n_aw = 1; e.n_w = 1;
    end else begin
      v = '0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = mb[(a8 + i) % 256];
      if (sx && n < 4) for (int k = 8*n; k < 32; k++) v[k] = v[8*n-1];
      exp_araddr  = a & ~32'd3;
      model_rdata = v;
      e.err = ie; e.rdata = v; e.n_ar = 1;
    end
    @(negedge clk);
    aw_wait = daw; w_wait = dw; b_dly = db; ar_wait = dar; r_dly = dr; inj_err = ie;
    aw_hs = 0; w_hs = 0; ar_hs = 0; bus_act = 0;
    sb.push_back(e);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_size = sz; cpu_sign_ext = sx;
    @(posedge clk);
    #1;
    // Junk on the CPU side while busy must be ignored.
    cpu_req = 1'($urandom); cpu_we = 1'($urandom); cpu_addr = $urandom; cpu_wdata = $urandom;
    cpu_size = 2'($urandom); cpu_sign_ext = 1'($urandom);
    cyc = 0;
    done_seen = 1'b0;
    while (cyc < 200 && !done_seen) begin
      @(negedge clk);
      cyc++;
      if (cpu_done) done_seen = 1'b1;
      else check1("stall_while_busy", cpu_stall, 1'b1);
    end
    cpu_req = 1'b0;
    if (!done_seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=none required=done");
      summary();
    end
    check1("stall_in_done", cpu_stall, 1'b0);
    if (exp_lat > 0) check32("latency", cyc, exp_lat);
  endtask

  initial begin
    #1_000_000;
    checks++;
    errors++;
    $display("FAIL watchdog actual=running required=finished");
    summary();
  end

  initial begin
    int          tmo;
    logic [31:0] w, a;
    logic [1:0]  sz;
    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      smem[i] = w;
      for (int k = 0; k < 4; k++) mb[4*i + k] = w[8*k +: 8];
    end
    aw_wait = 0; w_wait = 0; b_dly = 0; ar_wait = 0; r_dly = 0;
    exp_awaddr = '0; exp_wdata = '0; exp_araddr = '0; exp_wstrb = '0;
    repeat (2) @(negedge clk);
    check1("rst_awvalid", axi.M_AXI_AWVALID, 1'b0);
    check1("rst_wvalid", axi.M_AXI_WVALID, 1'b0);
    check1("rst_arvalid", axi.M_AXI_ARVALID, 1'b0);
    check1("rst_bready", axi.M_AXI_BREADY, 1'b0);
    check1("rst_rready", axi.M_AXI_RREADY, 1'b0);
    check1("rst_done", cpu_done, 1'b0);
    check1("rst_err", cpu_err, 1'b0);
    check1("rst_stall", cpu_stall, 1'b0);
    check32("rst_rdata", cpu_rdata, 32'h0);
    check32("rst_awaddr", axi.M_AXI_AWADDR, 32'h0);
    check32("rst_araddr", axi.M_AXI_ARADDR, 32'h0);
    check32("rst_wdata", axi.M_AXI_WDATA, 32'h0);
    check32("rst_wstrb", {28'd0, axi.M_AXI_WSTRB}, 32'h0);
    rst_n = 1'b1;

    // Zero-wait store/load: done in the fourth cycle counting the request cycle.
    run_txn(1, 32'h100, 32'hDEADBEEF, SZ_WORD, 0, 0, 0, 0, 0, 0, 0, 3);
    run_txn(0, 32'h100, 32'h0, SZ_WORD, 0, 0, 0, 0, 0, 0, 0, 3);
    run_txn(1, 32'h103, 32'h000000A5, SZ_BYTE, 0, 0, 0, 0, 0, 0, 0, 3);
    run_txn(0, 32'h103, 32'h0, SZ_BYTE, 1, 0, 0, 0, 0, 0, 0, 3);
    run_txn(0, 32'h103, 32'h0, SZ_BYTE, 0, 0, 0, 0, 0, 0, 0, 3);
    run_txn(1, 32'h100, 32'h80011234, SZ_WORD, 0, 0, 0, 0, 0, 0, 0, 0);
    run_txn(0, 32'h102, 32'h0, SZ_HALF, 1, 0, 0, 0, 0, 0, 0, 0);
    // AW accepted three cycles ahead of W, late B.
    run_txn(1, 32'h104, 32'h13572468, SZ_WORD, 0, 0, 0, 3, 5, 0, 0, 0);
    run_txn(0, 32'h104, 32'h0, SZ_WORD, 0, 0, 0, 0, 0, 2, 3, 0);
    // Misaligned accesses complete with an error and never touch the bus.
    run_txn(0, 32'h102, 32'h0, SZ_WORD, 0, 0, 0, 0, 0, 0, 0, 1);
    run_txn(1, 32'h101, 32'hFFFF, SZ_HALF, 0, 0, 0, 0, 0, 0, 0, 1);
    // Slave errors still return data / update memory.
    run_txn(0, 32'h104, 32'h0, SZ_WORD, 0, 1, 0, 0, 0, 0, 0, 0);
    run_txn(1, 32'h108, 32'hCAFEF00D, SZ_WORD, 0, 1, 0, 0, 0, 0, 0, 0);
    run_txn(0, 32'h108, 32'h0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset while the load waits for read data.
    @(negedge clk);
    exp_araddr = 32'h140; inj_err = 1'b0; ar_wait = 0; r_dly = 1000;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h140; cpu_size = SZ_WORD; cpu_sign_ext = 1'b0;
    @(posedge clk);
    #1 cpu_req = 1'b0;
    tmo = 0;
    while (tmo < 20 && !axi.M_AXI_RREADY) begin
      @(negedge clk);
      tmo++;
    end
    check1("reached_rd_data", axi.M_AXI_RREADY, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check1("abort_rready", axi.M_AXI_RREADY, 1'b0);
    check1("abort_arvalid", axi.M_AXI_ARVALID, 1'b0);
    check1("abort_awvalid", axi.M_AXI_AWVALID, 1'b0);
    check1("abort_wvalid", axi.M_AXI_WVALID, 1'b0);
    check1("abort_bready", axi.M_AXI_BREADY, 1'b0);
    check1("abort_stall", cpu_stall, 1'b0);
    check32("abort_rdata", cpu_rdata, 32'h0);
    r_pend = 1'b0;
    axi.M_AXI_RVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check1("abort_no_done", cpu_done, 1'b0);
    end
    rst_n = 1'b1;
    model_rdata = '0;

    for (int t = 0; t < 300; t++) begin
      a  = $urandom;
      sz = 2'($urandom);
      if ($urandom_range(3) != 0) a[1:0] = (sz == SZ_BYTE) ? a[1:0] : (sz == SZ_HALF) ? {a[1], 1'b0} : 2'b00;
      run_txn(1'($urandom), a, $urandom, sz, 1'($urandom), ($urandom_range(7) == 0),
              $urandom_range(3), $urandom_range(3), $urandom_range(3),
              $urandom_range(3), $urandom_range(3), 0);
    end

    repeat (4) @(negedge clk);
    check32("scoreboard_drained", sb.size(), 32'd0);
    summary();
  end

endmodule
